// File: rtl/mext_sequencer.sv
// Sequencer between the execute stage and an iterative multiply/divide unit.
// It stalls the pipeline while the unit runs, resolves trivial divides locally, and absorbs flushes.
`timescale 1ns/1ps
module mext_sequencer #(
  parameter int XLEN    = 32,
  parameter int MAX_LAT = 40,
  parameter int CNT_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid_i,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            unit_start_o,
  output logic [2:0]      unit_op_o,
  output logic [XLEN-1:0] unit_a_o,
  output logic [XLEN-1:0] unit_b_o,
  input  logic            unit_done_i,
  input  logic [XLEN-1:0] unit_result_i,
  output logic            stall_o,
  output logic            flagM_o,
  output logic [XLEN-1:0] result_m_o,
  output logic            busy_o,
  output logic            wdog_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_t;

  localparam logic [4:0]       OP_FIRST = 5'b01011;
  localparam logic [4:0]       OP_LAST  = 5'b10010;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LAT - 1);
  localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  state_t          w_next;
  logic            r_start;
  logic            r_busy;
  logic            r_flag;
  logic            r_wdog;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;

  logic            w_is_mop;
  logic            w_accept;
  logic [2:0]      w_op_idx;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;
  logic            w_timeout;
  logic            w_stall;
  logic            w_wait_done;
  logic            w_wait_tmo;
  logic            w_drain_tmo;

  assign w_is_mop    = (alu_op_i >= OP_FIRST) && (alu_op_i <= OP_LAST);
  assign w_op_idx    = 3'(alu_op_i - OP_FIRST);
  assign w_accept    = (r_state == S_IDLE) && op_valid_i && w_is_mop && !flush_i;
  assign w_b_zero    = (src_b_i == '0);
  assign w_ovf       = (src_a_i == SMIN) && (src_b_i == '1);
  assign w_timeout   = (r_cnt >= CNT_LAST);
  assign w_wait_done = (r_state == S_WAIT) && !flush_i && unit_done_i;
  assign w_wait_tmo  = (r_state == S_WAIT) && !flush_i && !unit_done_i && w_timeout;
  assign w_drain_tmo = (r_state == S_DRAIN) && !unit_done_i && w_timeout;

  // Divide-by-zero and signed overflow have architecturally fixed results, so skip the unit.
  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = '0;
    case (w_op_idx)
      3'd4: begin
        if (w_b_zero) begin
          w_fast = 1'b1; w_fast_res = '1;
        end else if (w_ovf) begin
          w_fast = 1'b1; w_fast_res = SMIN;
        end else begin
          w_fast = 1'b0; w_fast_res = '0;
        end
      end
      3'd5: begin
        if (w_b_zero) begin
          w_fast = 1'b1; w_fast_res = '1;
        end else begin
          w_fast = 1'b0; w_fast_res = '0;
        end
      end
      3'd6: begin
        if (w_b_zero) begin
          w_fast = 1'b1; w_fast_res = src_a_i;
        end else if (w_ovf) begin
          w_fast = 1'b1; w_fast_res = '0;
        end else begin
          w_fast = 1'b0; w_fast_res = '0;
        end
      end
      3'd7: begin
        if (w_b_zero) begin
          w_fast = 1'b1; w_fast_res = src_a_i;
        end else begin
          w_fast = 1'b0; w_fast_res = '0;
        end
      end
      default: begin
        w_fast = 1'b0; w_fast_res = '0;
      end
    endcase
  end

  // Next-state decode and the combinational pipeline stall.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_accept;
        if (w_accept) w_next = w_fast ? S_DONE : S_ISSUE;
        else          w_next = S_IDLE;
      end
      S_ISSUE: begin
        w_stall = 1'b1;
        w_next  = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (flush_i)                        w_next = unit_done_i ? S_IDLE : S_DRAIN;
        else if (unit_done_i || w_timeout)  w_next = S_DONE;
        else                                w_next = S_WAIT;
      end
      S_DONE: begin
        w_stall = 1'b0;
        w_next  = S_IDLE;
      end
      S_DRAIN: begin
        // A younger M-op must wait until the abandoned operation leaves the unit.
        w_stall = op_valid_i && w_is_mop && !flush_i;
        if (unit_done_i || w_timeout) w_next = S_IDLE;
        else                          w_next = S_DRAIN;
      end
      default: begin
        w_stall = 1'b0;
        w_next  = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Registered outputs, operand latch, result capture and watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_flag   <= 1'b0;
      r_wdog   <= 1'b0;
      r_op     <= 3'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      r_start <= (w_next == S_ISSUE);
      r_busy  <= (w_next == S_ISSUE) || (w_next == S_WAIT) || (w_next == S_DRAIN);
      r_flag  <= (w_next == S_DONE);
      if (w_accept) begin
        r_op <= w_op_idx;
        r_a  <= src_a_i;
        r_b  <= src_b_i;
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      else if (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !w_timeout) r_cnt <= r_cnt + CNT_W'(1);
      if (w_wait_tmo || w_drain_tmo) r_wdog <= 1'b1;
      if (w_accept && w_fast) r_result <= w_fast_res;
      else if (w_wait_done)   r_result <= unit_result_i;
      else if (w_wait_tmo)    r_result <= '0;
    end
  end

  assign unit_start_o = r_start;
  assign unit_op_o    = r_op;
  assign unit_a_o     = r_a;
  assign unit_b_o     = r_b;
  assign stall_o      = w_stall;
  assign flagM_o      = r_flag;
  assign result_m_o   = r_result;
  assign busy_o       = r_busy;
  assign wdog_err_o   = r_wdog;

endmodule

// File: tb/tb_mext_sequencer.sv
// Directed self-checking bench for mext_sequencer; the bench itself plays the multiply/divide unit.
`timescale 1ns/1ps
module tb_mext_sequencer;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  logic        clk;
  logic        rst;
  logic        op_valid_i;
  logic [4:0]  alu_op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        unit_start_o;
  logic [2:0]  unit_op_o;
  logic [31:0] unit_a_o;
  logic [31:0] unit_b_o;
  logic        unit_done_i;
  logic [31:0] unit_result_i;
  logic        stall_o;
  logic        flagM_o;
  logic [31:0] result_m_o;
  logic        busy_o;
  logic        wdog_err_o;

  int n_vec;
  int n_err;

  mext_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid_i    (op_valid_i),
    .alu_op_i      (alu_op_i),
    .src_a_i       (src_a_i),
    .src_b_i       (src_b_i),
    .flush_i       (flush_i),
    .unit_start_o  (unit_start_o),
    .unit_op_o     (unit_op_o),
    .unit_a_o      (unit_a_o),
    .unit_b_o      (unit_b_o),
    .unit_done_i   (unit_done_i),
    .unit_result_i (unit_result_i),
    .stall_o       (stall_o),
    .flagM_o       (flagM_o),
    .result_m_o    (result_m_o),
    .busy_o        (busy_o),
    .wdog_err_o    (wdog_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Holds one instruction in execute until flagM_o, modelling a unit of latency lat (or a hung unit).
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic hang,
                        input logic [31:0] unit_res, input int exp_flag_cyc,
                        input int exp_starts, input logic [2:0] exp_idx,
                        input logic [31:0] exp_res);
    int n_stall;
    int n_start;
    int flag_cyc;
    logic [2:0]  seen_op;
    logic [31:0] seen_a;
    logic [31:0] seen_b;
    n_stall = 0; n_start = 0; flag_cyc = -1;
    seen_op = 3'd0; seen_a = 32'd0; seen_b = 32'd0;
    for (int c = 0; c < 100 && flag_cyc < 0; c++) begin
      op_valid_i    = 1'b1;
      alu_op_i      = op;
      src_a_i       = a;
      src_b_i       = b;
      unit_done_i   = !hang && (c == 1 + lat);
      unit_result_i = unit_done_i ? unit_res : 32'd0;
      #1;
      if (stall_o) n_stall++;
      if (unit_start_o) begin
        n_start++;
        seen_op = unit_op_o;
        seen_a  = unit_a_o;
        seen_b  = unit_b_o;
      end
      if (flagM_o) flag_cyc = c;
      else cyc();
    end
    unit_done_i   = 1'b0;
    unit_result_i = 32'd0;
    check_eq({tag, "_flag_cycle"}, 32'(flag_cyc), 32'(exp_flag_cyc));
    check_eq({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_flag_cyc));
    check_eq({tag, "_start_pulses"}, 32'(n_start), 32'(exp_starts));
    check_eq({tag, "_result"}, result_m_o, exp_res);
    check_eq({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
    check_eq({tag, "_busy_in_done"}, 32'(busy_o), 32'd0);
    if (exp_starts > 0) begin
      check_eq({tag, "_unit_op"}, 32'(seen_op), 32'(exp_idx));
      check_eq({tag, "_unit_a"}, seen_a, a);
      check_eq({tag, "_unit_b"}, seen_b, b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n_flag;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0; op_valid_i = 1'b0; alu_op_i = 5'd0; src_a_i = 32'd0; src_b_i = 32'd0;
    flush_i = 1'b0; unit_done_i = 1'b0; unit_result_i = 32'd0;
    repeat (2) cyc();
    check_eq("rst_outputs", {26'd0, unit_start_o, stall_o, flagM_o, busy_o, wdog_err_o, 1'b0}, 32'd0);
    check_eq("rst_result", result_m_o, 32'd0);
    rst = 1'b1;
    cyc();

    // Codes just outside the M range and a flushed M-op are not accepted.
    op_valid_i = 1'b1; alu_op_i = 5'b01010; #1;
    check_eq("below_range_stall", 32'(stall_o), 32'd0);
    cyc(); alu_op_i = 5'b10011; #1;
    check_eq("below_range_state", {29'd0, unit_start_o, busy_o, flagM_o}, 32'd0);
    check_eq("above_range_stall", 32'(stall_o), 32'd0);
    cyc(); alu_op_i = OP_MUL; flush_i = 1'b1; #1;
    check_eq("above_range_state", {29'd0, unit_start_o, busy_o, flagM_o}, 32'd0);
    check_eq("flush_accept_stall", 32'(stall_o), 32'd0);
    cyc(); op_valid_i = 1'b0; flush_i = 1'b0; #1;
    check_eq("flush_accept_state", {29'd0, unit_start_o, busy_o, flagM_o}, 32'd0);
    cyc();

    run_op("mul", OP_MUL, 32'd7, 32'd6, 32, 1'b0, 32'd42, 34, 1, 3'd0, 32'd42);
    // Next instruction is an ADD: no extra stall once the MUL is released.
    cyc(); alu_op_i = OP_ADD; #1;
    check_eq("add_after_mul_stall", 32'(stall_o), 32'd0);
    check_eq("add_after_mul_flag", 32'(flagM_o), 32'd0);
    cyc(); op_valid_i = 1'b0; #1;
    check_eq("add_after_mul_busy", {30'd0, busy_o, unit_start_o}, 32'd0);
    cyc();

    run_op("divu0", OP_DIVU, 32'd100, 32'd0, 50, 1'b0, 32'd0, 1, 0, 3'd5, 32'hFFFF_FFFF);
    cyc(); op_valid_i = 1'b0;
    run_op("remu0", OP_REMU, 32'd100, 32'd0, 50, 1'b0, 32'd0, 1, 0, 3'd7, 32'd100);
    cyc(); op_valid_i = 1'b0;
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 50, 1'b0, 32'd0, 1, 0, 3'd6, 32'd0);
    cyc(); op_valid_i = 1'b0;
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 50, 1'b0, 32'd0, 1, 0, 3'd4,
           32'h8000_0000);
    cyc(); op_valid_i = 1'b0;
    cyc();

    // MULHU flushed mid-WAIT: unit drains, result discarded, younger M-op held off.
    op_valid_i = 1'b1; alu_op_i = OP_MULHU; src_a_i = 32'h11; src_b_i = 32'h22; #1;
    check_eq("fl_accept_stall", 32'(stall_o), 32'd1);
    cyc();
    check_eq("fl_start", 32'(unit_start_o), 32'd1);
    check_eq("fl_unit_op", 32'(unit_op_o), 32'd3);
    repeat (5) cyc();
    flush_i = 1'b1; op_valid_i = 1'b0; #1;
    check_eq("fl_wait_stall", 32'(stall_o), 32'd1);
    n_flag = 0;
    cyc(); flush_i = 1'b0; #1;
    n_flag += int'(flagM_o);
    check_eq("fl_drain_stall", 32'(stall_o), 32'd0);
    check_eq("fl_drain_busy", 32'(busy_o), 32'd1);
    cyc(); op_valid_i = 1'b1; alu_op_i = OP_MUL; #1;
    n_flag += int'(flagM_o);
    check_eq("fl_drain_new_op_stall", 32'(stall_o), 32'd1);
    cyc(); op_valid_i = 1'b0; unit_done_i = 1'b1; unit_result_i = 32'hDEAD_BEEF; #1;
    n_flag += int'(flagM_o);
    check_eq("fl_drain_busy_late", 32'(busy_o), 32'd1);
    check_eq("fl_drain_no_accept", 32'(unit_start_o), 32'd0);
    cyc(); unit_done_i = 1'b0; unit_result_i = 32'd0; #1;
    n_flag += int'(flagM_o);
    check_eq("fl_idle_busy", 32'(busy_o), 32'd0);
    check_eq("fl_no_flag", 32'(n_flag), 32'd0);
    check_eq("fl_result_kept", result_m_o, 32'h8000_0000);
    cyc();

    // Flush coinciding with done in WAIT returns straight to IDLE.
    op_valid_i = 1'b1; alu_op_i = OP_MULH; src_a_i = 32'd3; src_b_i = 32'd4;
    cyc(); op_valid_i = 1'b0;
    cyc(); flush_i = 1'b1; unit_done_i = 1'b1; unit_result_i = 32'h1111_1111;
    cyc(); flush_i = 1'b0; unit_done_i = 1'b0; unit_result_i = 32'd0; #1;
    check_eq("fl_done_state", {29'd0, busy_o, flagM_o, stall_o}, 32'd0);
    check_eq("fl_done_result", result_m_o, 32'h8000_0000);
    cyc();

    run_op("wdog", OP_MULH, 32'd3, 32'd5, 0, 1'b1, 32'd0, 42, 1, 3'd1, 32'd0);
    check_eq("wdog_err", 32'(wdog_err_o), 32'd1);
    cyc(); op_valid_i = 1'b0;
    run_op("mulhsu", OP_MULHSU, 32'd9, 32'd2, 3, 1'b0, 32'h1234, 5, 1, 3'd2, 32'h1234);
    check_eq("wdog_sticky", 32'(wdog_err_o), 32'd1);
    cyc(); op_valid_i = 1'b0;
    cyc();

    // Reset in the middle of WAIT, then a late done from the abandoned operation.
    op_valid_i = 1'b1; alu_op_i = OP_MUL; src_a_i = 32'd9; src_b_i = 32'd9;
    cyc(); op_valid_i = 1'b0;
    repeat (2) cyc();
    rst = 1'b0; #1;
    check_eq("midrst_outputs", {26'd0, unit_start_o, stall_o, flagM_o, busy_o, wdog_err_o, 1'b0},
             32'd0);
    check_eq("midrst_result", result_m_o, 32'd0);
    check_eq("midrst_unit_a", unit_a_o, 32'd0);
    cyc(); rst = 1'b1;
    cyc(); unit_done_i = 1'b1; unit_result_i = 32'h5555_5555;
    cyc(); unit_done_i = 1'b0; unit_result_i = 32'd0; #1;
    check_eq("late_done_state", {29'd0, busy_o, flagM_o, stall_o}, 32'd0);
    check_eq("late_done_result", result_m_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
